// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor, diff = a - b (mod 2^WIDTH), one bit per clock through one shared cell.
// Latency: done pulses in the cycle that starts WIDTH edges after the start-accepting edge; busy is high for those WIDTH cycles.
// Backpressure: start is accepted only when busy==0 (IDLE or DONE); start while busy is ignored and operands are not re-sampled.
//
// Ports: clk, rst (sync, active-high), start/a/b request in; busy/done handshake out; diff/borr result out (held until next completion).
// Optional: define SERIAL_SUB_ZERO_FLAG_EN to add registered output 'zero' (1 when the completed diff == 0).
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borr
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borr_q, borr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    // Shared 1-bit subtract cell, built as two half-subtractor stages.
    logic cell_x, cell_y, hs1_d, hs1_b, hs2_b, cell_d, cell_bout;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        cell_x    = a_sh_q[0];
        cell_y    = b_sh_q[0];
        hs1_d     = cell_x ^ cell_y;
        hs1_b     = ~cell_x & cell_y;
        cell_d    = hs1_d ^ bw_q;
        hs2_b     = ~hs1_d & bw_q;
        cell_bout = hs1_b | hs2_b;
        // Result bits enter from the MSB side so that after WIDTH shifts bit 0 sits at the LSB.
        res_next  = {cell_d, res_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        diff_d  = diff_q;
        borr_d  = borr_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif

        case (state_q)
            // DONE accepts start exactly like IDLE so back-to-back ops have no idle gap.
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    bw_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_next;
                bw_d   = cell_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d  = res_next;
                    borr_d  = cell_bout;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                    zero_d  = (res_next == '0);
`endif
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            diff_q  <= '0;
            borr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            diff_q  <= diff_d;
            borr_q  <= borr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign borr = borr_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    assign zero = zero_q;
`endif

endmodule
